mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-access sequencer between the multi-cycle control FSM and the shared instruction/data memory. It converts the FSM's single-state MemRead/MemWrite strobes into a req/ack handshake with a variable-latency memory and owns the instruction register (IR) and memory data register (MDR). It raises `stall` so the FSM holds its current state until the access completes.

## Interface
Parameters:
- `DATA_W`, 8, memory word / register width
- `ADDR_W`, 8, memory address width
- `TIMEOUT`, 15, max BUSY cycles without ack before abort (used only with `MEM_TIMEOUT_EN`)

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `MemRead` in 1: read strobe from FSM
- `MemWrite` in 1: write strobe from FSM
- `AddrSel` in 1: 1 = address from `pc`, 0 = address from `r2`
- `IRload` in 1: read result goes to IR
- `MDRload` in 1: read result goes to MDR
- `pc` in ADDR_W: program counter
- `r2` in ADDR_W: register-sourced address
- `r1` in DATA_W: store data
- `mem_req` out 1: request to memory, held until ack
- `mem_we` out 1: 1 = write, valid while `mem_req`
- `mem_addr` out ADDR_W: latched address
- `mem_wdata` out DATA_W: latched store data
- `mem_ack` in 1: one-cycle completion from memory
- `mem_rdata` in DATA_W: read data, valid with `mem_ack`
- `ir` out DATA_W: instruction register
- `mdr` out DATA_W: memory data register
- `stall` out 1: FSM must hold state while high
- `bus_err` out 1: sticky timeout flag

## Operation
- Reset (asserted low): state IDLE. `mem_req`, `mem_we`, `stall`, and `bus_err` are 0. `mem_addr`, `mem_wdata`, `ir`, and `mdr` are all-zero.
- States: IDLE, BUSY, DONE.
- IDLE: if `MemRead|MemWrite` is high, `stall` is 1 combinationally in the same cycle. At the next edge:
  - latch address (`AddrSel ? pc : r2`), `r1`, `mem_we = MemWrite`, and destination flags (`IRload`, `MDRload`)
  - go to BUSY
- BUSY: `mem_req` = 1 and `stall` = 1. On an edge with `mem_ack` high, go to DONE. If the access was a read:
  - if the IR flag is latched, `ir <= mem_rdata`
  - if the MDR flag is latched, `mdr <= mem_rdata`
  - if both are latched, both load
  - if neither is latched, the data is discarded
- DONE: `mem_req` = 0 and `stall` = 0, so the FSM advances on this edge. Strobes are ignored here so the same strobe is not re-issued. Go to IDLE.
- `MemRead` and `MemWrite` both high: write wins, read is ignored.
- `mem_ack` outside BUSY is ignored.
- Input changes while in BUSY are ignored; the latched values are used.
- Reset mid-transaction: `mem_req` drops asynchronously and state returns to IDLE. The memory must tolerate an abandoned request.

## Timing
- Strobe seen in IDLE at cycle T; `mem_req` is high from T+1.
- Ack in cycle T+k (k ≥ 1): DONE at T+k+1, and the FSM leaves its state at the end of T+k+1.
- Minimum cost is 3 cycles per memory-access FSM state (k = 1).
- `ir`/`mdr` update at the edge ending cycle T+k, so they are visible in DONE.
- `stall` is combinational from state and strobes only, with no path from `mem_ack`.
- The FSM's state register is gated by `~stall`.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - a BUSY-cycle counter starts at 0 on entry to BUSY
  - if TIMEOUT cycles elapse with no ack, the access is aborted: go to DONE, `ir`/`mdr` are unchanged, `bus_err` is set
  - `bus_err` is cleared only by reset
  - an ack in the same cycle as the timeout counts as success
- `MEM_TIMEOUT_EN` undefined: BUSY waits indefinitely, `bus_err` is tied to 0, and no counter logic exists.

## Structure
- Package `mem_ctrl_pkg`: state enum (IDLE/BUSY/DONE) and default `DATA_W`/`ADDR_W`/`TIMEOUT` constants.
- Sub-module `mem_watchdog` (instantiated only under `MEM_TIMEOUT_EN`):
  - inputs: clock, reset, enable = BUSY, clear on BUSY entry
  - output: one-cycle `expired` pulse

## Test plan
- Fetch, ack after 1 cycle: `MemRead=1, IRload=1, AddrSel=1, pc=0x10`, `mem_rdata=0xA4` → `mem_addr=0x10`, `mem_we=0`, `ir=0xA4` in DONE, `stall` high for exactly 2 cycles.
- Load, ack after 5 cycles: `AddrSel=0, r2=0x3C, MDRload=1`, data `0x5A` → `stall` high 6 cycles, `mdr=0x5A`, `ir` unchanged.
- Store: `MemWrite=1, r2=0x20, r1=0x77` → `mem_we=1`, `mem_addr=0x20`, `mem_wdata=0x77`; `ir`/`mdr` unchanged.
- Conflict/spurious: `MemRead=MemWrite=1` → write issued. `mem_ack` pulsed in IDLE → no state or register change.
- Reset low during BUSY → `mem_req=0` immediately, all outputs at reset values, next strobe is serviced normally.
- `MEM_TIMEOUT_EN`, `TIMEOUT=15`, no ack → abort after 15 BUSY cycles, `bus_err=1` sticky, `ir` unchanged. Without the macro → `stall` stays high and `bus_err=0`.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizes for the memory-access sequencer.
// Optional watchdog feature is selected with the MEM_TIMEOUT_EN macro.
package mem_ctrl_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_TIMEOUT = 15;

    // Sequencer states; encoding is also exported on the debug port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_watchdog.sv
// BUSY-cycle watchdog for the memory-access sequencer.
// Instantiated only when MEM_TIMEOUT_EN is defined.
// The counter is cleared on entry to BUSY and advances once per BUSY cycle.
// 'expired' pulses in the TIMEOUT-th BUSY cycle, when the sequencer must abort.
module mem_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // Count elapsed BUSY cycles; restart on every new access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Count 0 is the first BUSY cycle, so TIMEOUT-1 marks the last one allowed.
    always_comb begin
        expired = enable && (count == CNT_W'(TIMEOUT - 1));
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-access sequencer between the multi-cycle control FSM and the shared
// instruction/data memory. Turns single-state MemRead/MemWrite strobes into a
// req/ack transaction, owns IR and MDR, and stalls the FSM until completion.
// Define MEM_TIMEOUT_EN to add a BUSY watchdog that aborts and sets bus_err.
//
// Handshake: mem_req rises in the cycle after the strobe is seen and stays high
// until a cycle in which mem_ack is high; the access completes on that edge.
// mem_ack outside BUSY has no effect. mem_addr/mem_wdata/mem_we are stable
// for the whole time mem_req is high.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              AddrSel,
    input  logic              IRload,
    input  logic              MDRload,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] r2,
    input  logic [DATA_W-1:0] r1,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic              stall,
    output logic              bus_err,
    output logic [1:0]        dbg_state
);

    state_e state;
    state_e state_nxt;

    logic strobe;
    logic start;
    logic finish_ok;
    logic abort;
    logic ir_flag;
    logic mdr_flag;

    assign strobe    = MemRead | MemWrite;
    assign start     = (state == IDLE) && strobe;
    assign finish_ok = (state == BUSY) && mem_ack;
    assign dbg_state = state;

`ifdef MEM_TIMEOUT_EN
    logic expired;

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .enable  (state == BUSY),
        .clear   (start),
        .expired (expired)
    );

    // An ack in the expiry cycle wins, so abort only without ack.
    assign abort = expired && !mem_ack;

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_err <= 1'b0;
        end else if ((state == BUSY) && abort) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign abort   = 1'b0;
    assign bus_err = 1'b0;

    // Without a watchdog the TIMEOUT parameter has no function.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    // Next-state logic: IDLE -> BUSY on a strobe, BUSY -> DONE on ack or abort.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (strobe) state_nxt = BUSY;
            BUSY:    if (mem_ack || abort) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stall from state and strobes only; mem_ack never reaches this path.
    always_comb begin
        stall   = start || (state == BUSY);
        mem_req = (state == BUSY);
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the request when it is accepted; later input changes are ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            ir_flag   <= 1'b0;
            mdr_flag  <= 1'b0;
        end else if (start) begin
            mem_addr  <= AddrSel ? pc : r2;
            mem_wdata <= r1;
            mem_we    <= MemWrite;
            ir_flag   <= IRload;
            mdr_flag  <= MDRload;
        end
    end

    // Read data lands in IR and/or MDR on the acked edge; writes leave both.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir  <= '0;
            mdr <= '0;
        end else if (finish_ok && !mem_we) begin
            if (ir_flag)  ir  <= mem_rdata;
            if (mdr_flag) mdr <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed + randomized bench for mem_access_ctrl with a transaction-level
// reference model (expected IR/MDR, address queue, stall-cycle arithmetic).
// Honors MEM_TIMEOUT_EN to pick the matching timeout scenario.
module tb_mem_access_ctrl;

    logic       clock;
    logic       reset;
    logic       MemRead, MemWrite, AddrSel, IRload, MDRload;
    logic [7:0] pc, r2, r1;
    logic       mem_req, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [7:0] ir, mdr;
    logic       stall, bus_err;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_ir = 8'h00;
    logic [7:0] exp_mdr = 8'h00;
    logic       exp_bus_err = 1'b0;
    logic [7:0] exp_q[$];

    mem_access_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .AddrSel   (AddrSel),
        .IRload    (IRload),
        .MDRload   (MDRload),
        .pc        (pc),
        .r2        (r2),
        .r1        (r1),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .mdr       (mdr),
        .stall     (stall),
        .bus_err   (bus_err),
        .dbg_state (dbg_state)
    );

    // Clock generation
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete access with ack in the k-th BUSY cycle.
    task automatic access(input bit rd, input bit wr, input bit asel, input bit irl,
                          input bit mdrl, input logic [7:0] pcv, input logic [7:0] r2v,
                          input logic [7:0] r1v, input logic [7:0] dv, input int k);
        int stall_cycles;
        logic [7:0] ea;
        exp_q.push_back(asel ? pcv : r2v);
        @(negedge clock);
        MemRead = rd; MemWrite = wr; AddrSel = asel; IRload = irl; MDRload = mdrl;
        pc = pcv; r2 = r2v; r1 = r1v; mem_ack = 1'b0;
        #1;
        stall_cycles = 0;
        if (stall) stall_cycles++;
        check("stall_on_strobe", stall, 1);
        check("req_in_idle", mem_req, 0);
        for (int i = 1; i <= k; i++) begin
            @(negedge clock);
            if (stall) stall_cycles++;
            check("req_busy", mem_req, 1);
            check("we_busy", mem_we, wr);
            if (i == 1) begin
                ea = exp_q.pop_front();
                check("addr", mem_addr, ea);
                check("wdata", mem_wdata, r1v);
            end
            // Unlatched inputs move freely while the access is outstanding.
            pc = 8'($urandom); r2 = 8'($urandom); r1 = 8'($urandom);
            AddrSel = 1'($urandom); IRload = 1'($urandom); MDRload = 1'($urandom);
            mem_ack = (i == k);
            mem_rdata = (i == k) ? dv : 8'($urandom);
        end
        @(negedge clock);
        mem_ack = 1'b0;
        mem_rdata = 8'($urandom);
        if (rd && !wr) begin
            if (irl)  exp_ir  = dv;
            if (mdrl) exp_mdr = dv;
        end
        check("stall_done", stall, 0);
        check("req_done", mem_req, 0);
        check("state_done", dbg_state, 2);
        check("ir", ir, exp_ir);
        check("mdr", mdr, exp_mdr);
        check("bus_err", bus_err, exp_bus_err);
        check("stall_cycles", stall_cycles, k + 1);
        @(negedge clock);
        MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        check("stall_after", stall, 0);
        check("state_after", dbg_state, 0);
    endtask

    initial begin
        reset = 1'b0;
        MemRead = 0; MemWrite = 0; AddrSel = 0; IRload = 0; MDRload = 0;
        pc = 0; r2 = 0; r1 = 0; mem_ack = 0; mem_rdata = 0;

        // Reset values
        @(negedge clock);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_ir", ir, 0);
        check("rst_mdr", mdr, 0);
        check("rst_stall", stall, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b1;

        // Fetch, ack after 1 cycle
        access(1, 0, 1, 1, 0, 8'h10, 8'h99, 8'h00, 8'hA4, 1);
        // Load, ack after 5 cycles
        access(1, 0, 0, 0, 1, 8'h55, 8'h3C, 8'h00, 8'h5A, 5);
        // Store
        access(0, 1, 0, 0, 0, 8'h44, 8'h20, 8'h77, 8'hEE, 3);
        // Read and write together: write wins, no register load
        access(1, 1, 1, 1, 1, 8'h81, 8'h18, 8'hC3, 8'h3E, 2);

        // Spurious ack in IDLE
        @(negedge clock);
        mem_ack = 1'b1; mem_rdata = 8'hFF;
        #1;
        check("spur_stall", stall, 0);
        @(negedge clock);
        mem_ack = 1'b0;
        check("spur_state", dbg_state, 0);
        check("spur_req", mem_req, 0);
        check("spur_ir", ir, exp_ir);
        check("spur_mdr", mdr, exp_mdr);

        // Randomized accesses
        for (int n = 0; n < 24; n++) begin
            bit rd, wr;
            rd = 1'($urandom);
            wr = rd ? 1'($urandom) : 1'b1;
            access(rd, wr, 1'($urandom), 1'($urandom), 1'($urandom),
                   8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   $urandom_range(1, 6));
        end

        // Reset during BUSY
        @(negedge clock);
        MemRead = 1'b1; IRload = 1'b1; AddrSel = 1'b1; pc = 8'h6B;
        @(negedge clock);
        #1;
        check("pre_rst_req", mem_req, 1);
        #2;
        reset = 1'b0; MemRead = 1'b0; IRload = 1'b0;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_ir", ir, 0);
        check("mid_rst_mdr", mdr, 0);
        check("mid_rst_state", dbg_state, 0);
        exp_ir = 8'h00; exp_mdr = 8'h00; exp_bus_err = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        access(1, 0, 1, 1, 1, 8'h2D, 8'h00, 8'h00, 8'h96, 2);

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after 15 BUSY cycles
        @(negedge clock);
        MemRead = 1'b1; IRload = 1'b1; MDRload = 1'b1; mem_ack = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            check("to_stall", stall, 1);
            check("to_bus_err_low", bus_err, 0);
        end
        @(negedge clock);
        check("to_state", dbg_state, 2);
        check("to_stall_done", stall, 0);
        check("to_bus_err", bus_err, 1);
        check("to_ir", ir, exp_ir);
        check("to_mdr", mdr, exp_mdr);
        @(negedge clock);
        MemRead = 1'b0; IRload = 1'b0; MDRload = 1'b0;
        exp_bus_err = 1'b1;
        // Sticky through a later good access; ack in expiry cycle succeeds
        access(1, 0, 0, 0, 1, 8'h00, 8'h71, 8'h00, 8'hD2, 15);
`else
        // No watchdog: a long wait still completes without error
        access(1, 0, 0, 1, 0, 8'h00, 8'h71, 8'h00, 8'hD2, 40);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
